// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU and its clocked sequencer: the ALU
// command encodings, the sequencer FSM state encodings, the default
// datapath width and the settle-timer width with its load-value helper.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Width of the settle down-counter; bounds SETTLE_CYCLES to 1..255.
    localparam int SETTLE_W = 8;

    typedef logic [2:0] alu_cmd_t;
    typedef logic [1:0] seq_state_t;

    localparam alu_cmd_t CMD_ADD  = 3'd0;
    localparam alu_cmd_t CMD_SUB  = 3'd1;
    localparam alu_cmd_t CMD_XOR  = 3'd2;
    localparam alu_cmd_t CMD_SLT  = 3'd3;
    localparam alu_cmd_t CMD_AND  = 3'd4;
    localparam alu_cmd_t CMD_NAND = 3'd5;
    localparam alu_cmd_t CMD_NOR  = 3'd6;
    localparam alu_cmd_t CMD_OR   = 3'd7;

    localparam seq_state_t IDLE   = 2'd0;
    localparam seq_state_t SETTLE = 2'd1;
    localparam seq_state_t RESP   = 2'd2;

    // The timer counts the edges remaining after the first one, so the
    // sampling edge is the one at which the counter already reads zero.
    function automatic logic [SETTLE_W-1:0] settle_load_value(input int cycles);
        return SETTLE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_settle_timer.sv
// settle_timer
// 8-bit loadable down-counter that measures how long the ALU inputs have
// been held. Load has priority over enable; the counter stops at zero.
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset, clears the count
//   load       load load_value on the next edge
//   enable     decrement on the next edge (ignored while count is zero)
//   load_value value loaded by load
//   zero       count currently equals zero
module settle_timer
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                enable,
    input  logic [SETTLE_W-1:0] load_value,
    output logic                zero
);

    logic [SETTLE_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - SETTLE_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Clocked initiator for the combinational ALU. A request (a, b, cmd) is
// accepted over a valid/ready handshake and driven onto the ALU inputs,
// which are held for SETTLE_CYCLES edges before result and flags are
// sampled and offered as a response over a second valid/ready handshake.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_a, req_b, req_cmd        request operands and ALU command
//   alu_a, alu_b, alu_cmd        registered ALU inputs
//   alu_result, alu_carryout,
//   alu_zero, alu_overflow       ALU outputs
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_carryout,
//   rsp_zero, rsp_overflow       sampled ALU outputs
//   rsp_cmd                      command echo for the response
//   busy                         sequencer is not idle
//   op_count                     completed responses, wraps silently
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 4,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [2:0]         req_cmd,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_cmd,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carryout,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carryout,
    output logic               rsp_zero,
    output logic               rsp_overflow,
    output logic [2:0]         rsp_cmd,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
        $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [SETTLE_W-1:0] LOAD_VALUE = settle_load_value(SETTLE_CYCLES);

    seq_state_t state;
    logic       accept;
    logic       timer_zero;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    settle_timer u_settle_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept),
        .enable     (state == SETTLE),
        .load_value (LOAD_VALUE),
        .zero       (timer_zero)
    );

    // ALU operands and response data are only written at their own
    // handshake/sample points, so they retain the last operation's values
    // while idle; only reset returns them to zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_cmd      <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_cmd      <= '0;
            op_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a   <= req_a;
                        alu_b   <= req_b;
                        alu_cmd <= req_cmd;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer_zero) begin
                        rsp_result   <= alu_result;
                        rsp_carryout <= alu_carryout;
                        rsp_zero     <= alu_zero;
                        rsp_overflow <= alu_overflow;
                        rsp_cmd      <= alu_cmd;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + COUNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Scoreboard bench for alu_op_sequencer with a behavioural ALU attached.
// Every accepted request pushes the ALU response it should produce; a
// monitor on the falling edge checks handshake timing, held ALU inputs,
// retained response data and the completion counter against that model.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SETTLE = 4;
    localparam int CW     = 4;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             ovf;
        logic [2:0]       cmd;
    } rsp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_cmd;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_cmd;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carryout;
    logic             alu_zero;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carryout;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic [2:0]       rsp_cmd;
    logic             busy;
    logic [CW-1:0]    op_count;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;
    int rspMode     = 0;
    logic             overrideEn  = 1'b0;
    logic [WIDTH-1:0] overrideVal = '0;

    alu_op_sequencer #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE),
        .COUNT_W       (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cmd      (req_cmd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cmd      (alu_cmd),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_cmd      (rsp_cmd),
        .busy         (busy),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural 32-bit ALU: what the real ALU computes for each command.
    function automatic rsp_t aluEval(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [2:0] cmd);
        rsp_t r;
        logic [WIDTH:0] wide;
        r = '0;
        r.cmd = cmd;
        case (cmd)
            CMD_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r.result = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
                r.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r.result[WIDTH-1] != a[WIDTH-1]);
            end
            CMD_SUB: begin
                wide = {1'b0, a} + {1'b0, ~b} + 1;
                r.result = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
                r.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r.result[WIDTH-1] != a[WIDTH-1]);
            end
            CMD_XOR:  r.result = a ^ b;
            CMD_SLT:  r.result = ($signed(a) < $signed(b)) ? 1 : 0;
            CMD_AND:  r.result = a & b;
            CMD_NAND: r.result = ~(a & b);
            CMD_NOR:  r.result = ~(a | b);
            default:  r.result = a | b;
        endcase
        r.zero = (r.result == '0);
        return r;
    endfunction

    rsp_t aluNow;
    assign aluNow       = aluEval(alu_a, alu_b, alu_cmd);
    assign alu_result   = overrideEn ? overrideVal : aluNow.result;
    assign alu_carryout = aluNow.carry;
    assign alu_zero     = aluNow.zero;
    assign alu_overflow = aluNow.ovf;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic reportTimeout(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out at cycle %0d", name, cycle);
    endtask

    // Scoreboard state.
    rsp_t             expQ[$];
    rsp_t             lastRsp    = '0;
    logic [WIDTH-1:0] heldA      = '0;
    logic [WIDTH-1:0] heldB      = '0;
    logic [2:0]       heldCmd    = '0;
    int               acceptEdge = 0;
    int               modelCount = 0;
    bit               checkThroughput = 0;
    bit               tpArmed    = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            expQ.delete();
            lastRsp    = '0;
            heldA      = '0;
            heldB      = '0;
            heldCmd    = '0;
            modelCount = 0;
        end else begin
            bit expIdle;
            bit expValid;
            expIdle  = (expQ.size() == 0);
            expValid = !expIdle && (cycle >= acceptEdge + SETTLE);
            checkOutput("busy", busy, !expIdle);
            checkOutput("req_ready", req_ready, expIdle);
            checkOutput("alu_a", alu_a, heldA);
            checkOutput("alu_b", alu_b, heldB);
            checkOutput("alu_cmd", alu_cmd, heldCmd);
            checkOutput("op_count", op_count, modelCount % (1 << CW));
            checkOutput("rsp_valid", rsp_valid, expValid);
            if (expValid) begin
                checkOutput("rsp_result", rsp_result, expQ[0].result);
                checkOutput("rsp_carryout", rsp_carryout, expQ[0].carry);
                checkOutput("rsp_zero", rsp_zero, expQ[0].zero);
                checkOutput("rsp_overflow", rsp_overflow, expQ[0].ovf);
                checkOutput("rsp_cmd", rsp_cmd, expQ[0].cmd);
                if (rsp_ready) begin
                    lastRsp = expQ.pop_front();
                    modelCount++;
                end
            end else begin
                checkOutput("retained_result", rsp_result, lastRsp.result);
                checkOutput("retained_cmd", rsp_cmd, lastRsp.cmd);
            end
            if (req_valid && expIdle) begin
                expQ.push_back(aluEval(req_a, req_b, req_cmd));
                if (checkThroughput && tpArmed)
                    checkOutput("accept_interval", cycle + 1 - acceptEdge, SETTLE + 2);
                tpArmed    = checkThroughput;
                acceptEdge = cycle + 1;
                heldA      = req_a;
                heldB      = req_b;
                heldCmd    = req_cmd;
            end
        end
    end

    // Response consumer: always ready, random, or stalled.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rspMode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Present a request and hold it until accepted; with scramble set the
    // operands change every cycle the sequencer is busy.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] cmd, input bit scramble);
        int waited = 0;
        req_a = a;
        req_b = b;
        req_cmd = cmd;
        req_valid = 1'b1;
        forever begin
            if (scramble) begin
                req_a = $urandom;
                req_b = $urandom;
            end
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 60) begin
                reportTimeout("accept");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int waited = 0;
        forever begin
            @(negedge clk);
            if (expQ.size() == 0 && !busy) break;
            waited++;
            if (waited > 200) begin
                reportTimeout("drain");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    int slA[6] = '{-3, -4, 3, 4, 0, -4};
    int slB[6] = '{-4, -3, 4, 3, -3, 3};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int countBefore;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_cmd = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_busy", busy, 0);
        @(posedge clk);
        #1;

        // XOR of equal operands: zero result, single completion.
        applyStimulus(-32'sd4, -32'sd4, CMD_XOR, 0);
        waitIdle();
        checkOutput("t1_count", op_count, 1);
        checkOutput("t1_result", rsp_result, 0);
        checkOutput("t1_zero", rsp_zero, 1);
        checkOutput("t1_cmd", rsp_cmd, 2);

        // Signed less-than sweep with a randomly stalling consumer.
        rspMode = 1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(slA[i], slB[i], CMD_SLT, 0);
        end
        rspMode = 0;
        waitIdle();
        checkOutput("t2_last_slt", rsp_result, 1);

        // Back-pressure while the ALU output moves underneath the response.
        rspMode = 2;
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_1234, 32'h0000_0F0F, CMD_AND, 0);
        waited = 0;
        while (!rsp_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rsp_valid) reportTimeout("bp_rsp_valid");
        countBefore = modelCount;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            overrideEn  = 1'b1;
            overrideVal = $urandom;
            @(negedge clk);
            checkOutput("bp_req_ready", req_ready, 0);
            checkOutput("bp_result", rsp_result, 32'h0000_0204);
        end
        @(posedge clk);
        #1;
        overrideEn = 1'b0;
        rspMode = 0;
        waitIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_single_count", op_count, (countBefore + 1) % (1 << CW));

        // Reset two edges after acceptance discards the operation.
        applyStimulus(32'h0BAD_F00D, 32'h1, CMD_ADD, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_op_count", op_count, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("rst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk);
        #1;

        // Seventeen back-to-back adds wrap the 4-bit counter to 1.
        checkThroughput = 1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(i, 1, CMD_ADD, 0);
        end
        waitIdle();
        checkThroughput = 0;
        checkOutput("wrap_count", op_count, 1);
        checkOutput("wrap_last_result", rsp_result, 17);

        // Requests presented while busy must not disturb the ALU inputs.
        applyStimulus(32'h1234_5678, 32'h0000_0001, CMD_SUB, 0);
        applyStimulus(32'hAAAA_0000, 32'h0000_5555, CMD_OR, 1);
        waitIdle();

        // Random operations with boundary-biased operands.
        for (int i = 0; i < 40; i++) begin
            rspMode = $urandom_range(0, 1);
            applyStimulus(pickOperand(), pickOperand(), 3'($urandom_range(0, 7)), 0);
        end
        rspMode = 0;
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Clocked initiator for the combinational 32-bit ALU.
- Accepts one operation request (a, b, command) over a valid/ready handshake and drives it onto the ALU operand and command inputs.
- Holds those inputs stable for a programmable settle window, then samples result and flags.
- Presents the sampled values as a response over a second valid/ready handshake.
- Sits between a test/stimulus source or datapath controller and the ALU, replacing delay-based stimulus with a cycle-accurate, back-pressured interface.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
SETTLE_CYCLES, 4, cycles ALU inputs are held before sampling; legal range 1..255.
COUNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  synchronous active-low reset, sampled on rising clk.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept a request.
req_a  input  WIDTH  operand A, signed two's complement.
req_b  input  WIDTH  operand B, signed two's complement.
req_cmd  input  3  ALU command, encoded per alu_pkg.
alu_a  output  WIDTH  operand A to ALU.
alu_b  output  WIDTH  operand B to ALU.
alu_cmd  output  3  command to ALU.
alu_result  input  WIDTH  ALU result.
alu_carryout  input  1  ALU carry out.
alu_zero  input  1  ALU zero flag.
alu_overflow  input  1  ALU overflow flag.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_result  output  WIDTH  sampled result.
rsp_carryout  output  1  sampled carry out.
rsp_zero  output  1  sampled zero flag.
rsp_overflow  output  1  sampled overflow flag.
rsp_cmd  output  3  command echo for the response.
busy  output  1  high in any state other than IDLE.
op_count  output  COUNT_W  completed response handshakes; wraps modulo 2^COUNT_W.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low: when reset_n is low at a rising clk edge, the block enters IDLE and every register clears to 0.
  - Cleared registers: alu_a, alu_b, alu_cmd, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, rsp_cmd, rsp_valid, op_count, settle counter.
  - After reset: req_ready=1, busy=0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready at an edge: latch req_a/req_b/req_cmd into alu_a/alu_b/alu_cmd, load counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - req_ready=0; alu_* held constant.
  - Counter nonzero: decrement each edge.
  - Counter zero at an edge: sample alu_result/flags into rsp_*, set rsp_cmd=alu_cmd, set rsp_valid=1, go to RESP.
- RESP:
  - req_ready=0; rsp_* and rsp_valid held stable until rsp_ready.
  - On rsp_valid&&rsp_ready at an edge: clear rsp_valid, increment op_count, go to IDLE.
- Latency: request accepted at edge N gives rsp_valid high immediately after edge N+SETTLE_CYCLES.
- Throughput: with rsp_ready tied high, a back-to-back request is accepted at edge N+SETTLE_CYCLES+2.
- Retained values: alu_a/alu_b/alu_cmd keep the last operation's values in IDLE; they never return to 0 except on reset. rsp_* data keeps its last value after the handshake; only rsp_valid clears.
- Arithmetic: the block does no arithmetic on operands; values pass through bit-exact. op_count wraps from all-ones to 0 with no flag.
- Input during busy: req_valid asserted while busy is ignored with no side effects. The source must hold its request until req_ready.
- Reset mid-operation in SETTLE or RESP: the in-flight operation is discarded; rsp_valid=0 and op_count=0 on the next cycle.
- SETTLE_CYCLES=1: sampling occurs at the first edge after acceptance.

Decomposition:
- alu_pkg holds:
  - Command constants: CMD_ADD=0, CMD_SUB=1, CMD_XOR=2, CMD_SLT=3, CMD_AND=4, CMD_NAND=5, CMD_NOR=6, CMD_OR=7.
  - FSM state encodings: IDLE=0, SETTLE=1, RESP=2.
  - Default WIDTH.
- One sub-module is natural: settle_timer, an 8-bit loadable down-counter with load/enable inputs and a zero output.
- FSM and response registers stay in the top module.

Test Plan:
1. Reset, then SETTLE_CYCLES=4, real ALU attached, cmd=CMD_XOR, a=-4, b=-4 -> rsp_valid rises exactly 4 edges after acceptance; rsp_result=0, rsp_zero=1, rsp_cmd=2, op_count=1 after the handshake.
2. CMD_SLT sweep over pairs (-3,-4), (-4,-3), (3,4), (4,3), (0,-3), (-4,3) -> rsp_result = 0, 1, 1, 0, 0, 1 in order; the ALU inputs never change while busy=1.
3. Back-pressure: hold rsp_ready=0 for 10 cycles in RESP while changing alu_result externally -> rsp_result stays at the sampled value, req_ready=0 throughout; release gives a single handshake, op_count increments once.
4. Reset mid-SETTLE: drop reset_n for one edge 2 cycles after acceptance -> next cycle state IDLE, rsp_valid=0, alu_a=0, op_count=0, and no response is ever produced.
5. Wrap: COUNT_W=4, run 17 CMD_ADD operations (a=i, b=1) with rsp_ready=1 -> op_count reads 1 after the 17th handshake; each rsp_result equals i+1; accepts occur every 6 cycles.
6. Ignored request: req_valid held high with changing req_a during SETTLE and RESP -> alu_a stays at the originally accepted value; the next accept takes the req_a present in IDLE.
